// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the hazard scoreboard.
// Holds the forwarding-select encodings, the FSM state encoding, the
// hard-wired zero register index and the source/destination match helper.
package hazard_scoreboard_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;  // operand from register file
    localparam fwd_sel_t FWD_MEM = 2'b01;  // operand from MEM-stage result
    localparam fwd_sel_t FWD_WB  = 2'b10;  // operand from WB-stage result

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_LU_STALL = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a source that is actually read matches a destination that is
    // actually written. x0 never produces a hazard.
    function automatic logic src_hit(
        input logic       use_src,
        input logic [4:0] rs,
        input logic [4:0] rd,
        input logic       rd_en
    );
        return use_src & rd_en & (rd == rs) & (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter16.sv
// 16-bit saturating event counter.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   clear        : synchronous clear, wins over inc
//   inc          : count one event this cycle
//   count        : current count, holds at 0xFFFF
module sat_counter16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 16'h0000;
        end else if (clear) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline: load-use stall detection,
// branch flush, operand forwarding selects and stall/flush event counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal issue; load-use detection active
// ST_LU_STALL | one-cycle load-use stall; EX holds a bubble, no re-detection
//
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   id_valid                 : decode-stage instruction valid
//   id_rs1/2, id_use_rs1/2   : decode source registers and read enables
//   ex_rd, ex_reg_en         : EX-stage destination and write enable
//   ex_memtoreg, ex_pcsrc    : EX is a load / EX branch resolved taken
//   stall_if, stall_id       : hold PC / hold IF/ID
//   bubble_ex                : zero the ID/EX controls
//   flush_id                 : invalidate IF/ID
//   fwd_a, fwd_b             : operand selects for the instruction in EX
//   stall_cnt, flush_cnt     : saturating event counters
//   cnt_clr                  : synchronous counter clear
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_en,
    input  logic        ex_memtoreg,
    input  logic        ex_pcsrc,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    input  logic        cnt_clr
);

    logic [4:0] mem_rd;
    logic       mem_reg_en;
    logic [0:0] state;
    logic [0:0] state_nxt;

    logic       ex_hit_rs1, ex_hit_rs2;
    logic       mem_hit_rs1, mem_hit_rs2;
    logic       load_use;
    logic       lu_stall;
    logic       take_branch;
    fwd_sel_t   fwd_a_nxt, fwd_b_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_rd     <= REG_ZERO;
            mem_reg_en <= 1'b0;
        end else begin
            mem_rd     <= ex_rd;
            mem_reg_en <= ex_reg_en;
        end
    end

    assign ex_hit_rs1  = src_hit(id_use_rs1, id_rs1, ex_rd, ex_reg_en);
    assign ex_hit_rs2  = src_hit(id_use_rs2, id_rs2, ex_rd, ex_reg_en);
    assign mem_hit_rs1 = src_hit(id_use_rs1, id_rs1, mem_rd, mem_reg_en);
    assign mem_hit_rs2 = src_hit(id_use_rs2, id_rs2, mem_rd, mem_reg_en);

    // In LU_STALL the EX slot holds the bubble we inserted, so a match there
    // is stale and must not stall again.
    assign load_use = id_valid & (ex_hit_rs1 | ex_hit_rs2) & ex_memtoreg
                      & (state == ST_RUN);

    // Outputs are gated by reset so they read zero while reset is held,
    // regardless of the input pattern. A taken branch overrides load-use.
    assign take_branch = ex_pcsrc & ~reset;
    assign lu_stall    = load_use & ~ex_pcsrc & ~reset;

    assign stall_if  = lu_stall;
    assign stall_id  = lu_stall;
    assign flush_id  = take_branch;
    assign bubble_ex = lu_stall | take_branch;

    always_comb begin
        state_nxt = ST_RUN;
        if ((state == ST_RUN) && lu_stall) begin
            state_nxt = ST_LU_STALL;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A load in EX cannot forward its data from MEM next cycle, so only a
    // non-load EX match selects the MEM result; otherwise try the MEM entry.
    function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit && !ex_memtoreg) begin
            return FWD_MEM;
        end else if (mem_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign fwd_a_nxt = id_valid ? fwd_pick(ex_hit_rs1, mem_hit_rs1) : FWD_RF;
    assign fwd_b_nxt = id_valid ? fwd_pick(ex_hit_rs2, mem_hit_rs2) : FWD_RF;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (bubble_ex) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            fwd_a <= fwd_a_nxt;
            fwd_b <= fwd_b_nxt;
        end
    end

    sat_counter16 u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clr),
        .inc   (lu_stall),
        .count (stall_cnt)
    );

    sat_counter16 u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clr),
        .inc   (take_branch),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. Combinational hazard outputs are
// checked just after the inputs settle; registered results expected after the
// next edge are queued when the stimulus is driven and popped after the edge.
module tb_hazard_scoreboard;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_en, ex_memtoreg, ex_pcsrc;
    logic        stall_if, stall_id, bubble_ex, flush_id;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    logic        cnt_clr;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_sc = 16'd0;
    logic [15:0] exp_fc = 16'd0;

    hazard_scoreboard dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_reg_en   (ex_reg_en),
        .ex_memtoreg (ex_memtoreg),
        .ex_pcsrc    (ex_pcsrc),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .bubble_ex   (bubble_ex),
        .flush_id    (flush_id),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .cnt_clr     (cnt_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] erd,
                         input logic een, input logic emtr, input logic epc, input logic clr);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        ex_rd       = erd;
        ex_reg_en   = een;
        ex_memtoreg = emtr;
        ex_pcsrc    = epc;
        cnt_clr     = clr;
    endtask

    // One cycle: drive at the falling edge, check hazards, queue the
    // registered expectations, then compare them after the rising edge.
    task automatic cyc(input string tag, input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] erd, input logic een, input logic emtr,
                       input logic epc, input logic clr,
                       input logic e_stall, input logic e_flush,
                       input logic [1:0] e_fa, input logic [1:0] e_fb);
        exp_t e;
        exp_t got;
        string t;
        drive(v, rs1, rs2, u1, u2, erd, een, emtr, epc, clr);
        #1;
        check({tag, ".stall_if"},  {31'd0, stall_if},  {31'd0, e_stall});
        check({tag, ".stall_id"},  {31'd0, stall_id},  {31'd0, e_stall});
        check({tag, ".bubble_ex"}, {31'd0, bubble_ex}, {31'd0, e_stall | e_flush});
        check({tag, ".flush_id"},  {31'd0, flush_id},  {31'd0, e_flush});
        if (clr) begin
            exp_sc = 16'd0;
            exp_fc = 16'd0;
        end else begin
            if (e_stall && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
            if (e_flush && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
        end
        e.fa = e_fa;
        e.fb = e_fb;
        e.sc = exp_sc;
        e.fc = exp_fc;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got none expected entry", tag);
        end else begin
            got = sb_q.pop_front();
            t   = tag_q.pop_front();
            check({t, ".fwd_a"},     {30'd0, fwd_a},     {30'd0, got.fa});
            check({t, ".fwd_b"},     {30'd0, fwd_b},     {30'd0, got.fb});
            check({t, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, got.sc});
            check({t, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, got.fc});
        end
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall_if"},  {31'd0, stall_if},  32'd0);
        check({tag, ".stall_id"},  {31'd0, stall_id},  32'd0);
        check({tag, ".bubble_ex"}, {31'd0, bubble_ex}, 32'd0);
        check({tag, ".flush_id"},  {31'd0, flush_id},  32'd0);
        check({tag, ".fwd_a"},     {30'd0, fwd_a},     32'd0);
        check({tag, ".fwd_b"},     {30'd0, fwd_b},     32'd0);
        check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
        check({tag, ".flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
    endtask

    initial begin
        // Reset with a load-use and a taken branch on the inputs.
        reset = 1'b1;
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        check_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        //  tag            v  rs1   rs2   u1 u2 erd   een emtr pc clr  stall flush fa     fb
        cyc("lu_detect",   1, 5'd5, 5'd0, 1, 0, 5'd5, 1,  1,   0, 0,   1,    0,    2'b00, 2'b00);
        cyc("lu_bubble",   1, 5'd5, 5'd0, 1, 0, 5'd5, 0,  0,   0, 0,   0,    0,    2'b10, 2'b00);
        cyc("no_valid",    0, 5'd5, 5'd0, 1, 0, 5'd5, 1,  1,   0, 0,   0,    0,    2'b00, 2'b00);
        cyc("alu_fwd_b",   1, 5'd0, 5'd7, 0, 1, 5'd7, 1,  0,   0, 0,   0,    0,    2'b00, 2'b01);
        cyc("x3_prep",     0, 5'd0, 5'd0, 0, 0, 5'd3, 1,  0,   0, 0,   0,    0,    2'b00, 2'b00);
        cyc("ex_prio",     1, 5'd3, 5'd0, 1, 0, 5'd3, 1,  0,   0, 0,   0,    0,    2'b01, 2'b00);
        cyc("mem_fwd",     1, 5'd3, 5'd9, 1, 1, 5'd9, 1,  0,   0, 0,   0,    0,    2'b10, 2'b01);
        cyc("noen_prep",   0, 5'd0, 5'd0, 0, 0, 5'd4, 0,  0,   0, 0,   0,    0,    2'b00, 2'b00);
        cyc("mem_noen",    1, 5'd4, 5'd0, 1, 0, 5'd4, 0,  0,   0, 0,   0,    0,    2'b00, 2'b00);
        cyc("use_off",     1, 5'd5, 5'd5, 0, 0, 5'd5, 1,  1,   0, 0,   0,    0,    2'b00, 2'b00);
        cyc("br_lu",       1, 5'd5, 5'd0, 1, 0, 5'd5, 1,  1,   1, 0,   0,    1,    2'b00, 2'b00);
        cyc("lu_after_br", 1, 5'd5, 5'd0, 1, 0, 5'd5, 1,  1,   0, 0,   1,    0,    2'b00, 2'b00);
        cyc("no_redetect", 1, 5'd5, 5'd0, 1, 0, 5'd5, 1,  1,   0, 0,   0,    0,    2'b10, 2'b00);
        cyc("x0_load",     1, 5'd0, 5'd0, 1, 1, 5'd0, 1,  1,   0, 0,   0,    0,    2'b00, 2'b00);
        cyc("x0_mem",      1, 5'd0, 5'd0, 1, 0, 5'd6, 1,  0,   0, 0,   0,    0,    2'b00, 2'b00);
        cyc("rs2_lu",      1, 5'd1, 5'd6, 1, 1, 5'd6, 1,  1,   0, 0,   1,    0,    2'b00, 2'b00);
        cyc("rs2_bubble",  1, 5'd1, 5'd6, 1, 1, 5'd0, 0,  0,   0, 0,   0,    0,    2'b00, 2'b10);
        cyc("clr_wins",    1, 5'd1, 5'd6, 1, 1, 5'd6, 1,  1,   0, 1,   1,    0,    2'b00, 2'b00);
        cyc("idle",        0, 5'd0, 5'd0, 0, 0, 5'd0, 0,  0,   0, 0,   0,    0,    2'b00, 2'b00);

        // Run the flush counter up to one below saturation without checks,
        // then verify the terminal value and that it holds.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (65534) @(posedge clock);
        @(negedge clock);
        exp_fc = 16'd65534;
        cyc("fc_sat_edge", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0,  0,   1, 0,   0,    1,    2'b00, 2'b00);
        cyc("fc_sat_hold", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0,  0,   1, 0,   0,    1,    2'b00, 2'b00);

        // Enter LU_STALL, then assert reset mid-cycle while in it.
        cyc("pre_rst_lu",  1, 5'd5, 5'd0, 1, 0, 5'd5, 1,  1,   0, 0,   1,    0,    2'b00, 2'b00);
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("lu_state.flush_id",  {31'd0, flush_id},  32'd1);
        check("lu_state.stall_if",  {31'd0, stall_if},  32'd0);
        check("lu_state.stall_cnt", {16'd0, stall_cnt}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("rst_in_stall");
        @(negedge clock);
        reset  = 1'b0;
        exp_sc = 16'd0;
        exp_fc = 16'd0;
        cyc("post_rst_lu", 1, 5'd5, 5'd0, 1, 0, 5'd5, 1,  1,   0, 0,   1,    0,    2'b00, 2'b00);
        cyc("post_bubble", 1, 5'd5, 5'd0, 1, 0, 5'd5, 0,  0,   0, 0,   0,    0,    2'b10, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
